// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Definitions shared by the pipeline hazard controller and its wait timer:
//   - REG_IDX_W / REG_ZERO : register index width and the hard-wired zero reg
//   - state_e              : hazard FSM encoding (RUN=0, MEM_WAIT=1)
//   - ctrl_t               : bundle of stage-register enables/flushes/bubble
//   - load_use_hit()       : load-use dependency check between EX and ID
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  localparam int WAIT_CNT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;

  // Pipeline advancing normally.
  localparam ctrl_t CTRL_RUN    = 7'b1111_000;
  // Values held while reset is asserted.
  localparam ctrl_t CTRL_RESET  = 7'b0000_000;
  // Data memory busy: freeze PC..EX/MEM, push a bubble into MEM/WB.
  localparam ctrl_t CTRL_MEM    = 7'b0000_001;
  // Taken branch: keep advancing but squash the two younger instructions.
  localparam ctrl_t CTRL_BRANCH = 7'b1111_110;
  // Load-use: hold PC and IF/ID one cycle, insert a NOP into ID/EX.
  localparam ctrl_t CTRL_LDUSE  = 7'b0011_010;

  // A load writing r0 never creates a dependency because r0 is constant.
  function automatic logic load_use_hit(
    input logic                 memread,
    input logic [REG_IDX_W-1:0] ex_rt,
    input logic [REG_IDX_W-1:0] id_rs,
    input logic [REG_IDX_W-1:0] id_rt
  );
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// -----------------------------------------------------------------------------
// pipe_wait_timer
// Saturating up-counter used as the data-memory wait watchdog.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-low reset (count -> 0)
//   clear_i  : load zero (takes priority over enable_i)
//   enable_i : count one more wait cycle, stopping at WAIT_MAX
//   hit_o    : the count reaches WAIT_MAX at the coming clock edge
// Parameter WAIT_MAX (1..65535): saturation value.
// -----------------------------------------------------------------------------
module pipe_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam logic [WAIT_CNT_W-1:0] MAX_V = WAIT_CNT_W'(WAIT_MAX);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Reported together with the edge that loads MAX_V so the sticky flag
  // upstream rises on the same edge as the count.
  assign hit_o = enable_i && !clear_i && (cnt_d == MAX_V);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a 5-stage pipeline: data-memory wait stalls, taken
// branch flushes and load-use interlocks, plus a sticky memory-wait watchdog.
// Priority: memory stall > branch flush > load-use.
// Ports:
//   clk_i, rst_i          : clock (rising edge), async active-low reset
//   IFID_rs_i, IFID_rt_i  : source registers of the instruction in ID
//   IDEX_MemRead_i        : instruction in EX is a load
//   IDEX_rt_i             : destination register of that load
//   EX_branch_taken_i     : branch/jump resolved taken in EX
//   MEM_req_i, MEM_ack_i  : data-memory request / completion in MEM
//   PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o : load enables
//   IFID_flush_o, IDEX_flush_o : load NOP into that stage register
//   MEMWB_bubble_o        : MEM/WB loads zero control
//   mem_timeout_o         : sticky watchdog flag, cleared only by reset
//   stall_cnt_o           : (HAZARD_PERF_CNT_EN only) cycles with PC_write_o=0
// Optional feature macro: HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] IFID_rs_i,
  input  logic [REG_IDX_W-1:0] IFID_rt_i,
  input  logic                 IDEX_MemRead_i,
  input  logic [REG_IDX_W-1:0] IDEX_rt_i,
  input  logic                 EX_branch_taken_i,
  input  logic                 MEM_req_i,
  input  logic                 MEM_ack_i,
  output logic                 PC_write_o,
  output logic                 IFID_write_o,
  output logic                 IDEX_write_o,
  output logic                 EXMEM_write_o,
  output logic                 IFID_flush_o,
  output logic                 IDEX_flush_o,
  output logic                 MEMWB_bubble_o,
  output logic                 mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  state_e state_q, state_d;
  logic   timeout_q, timeout_d;
  logic   mem_stall;
  logic   timer_clear, timer_enable, timer_hit;
  ctrl_t  ctrl;

  // Stall is decided purely from the live request/ack pair, so the first
  // request cycle stalls immediately and an ack releases in its own cycle.
  assign mem_stall = MEM_req_i & ~MEM_ack_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (MEM_ack_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Output decode; reset gates the outputs combinationally so they drop
  // as soon as rst_i falls, not on the next edge.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_i) begin
      ctrl = CTRL_RESET;
    end else if (mem_stall) begin
      ctrl = CTRL_MEM;
    end else if (EX_branch_taken_i) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use_hit(IDEX_MemRead_i, IDEX_rt_i, IFID_rs_i, IFID_rt_i)) begin
      // One cycle only: the NOP placed in ID/EX has MemRead=0.
      ctrl = CTRL_LDUSE;
    end
  end

  assign PC_write_o     = ctrl.pc_write;
  assign IFID_write_o   = ctrl.ifid_write;
  assign IDEX_write_o   = ctrl.idex_write;
  assign EXMEM_write_o  = ctrl.exmem_write;
  assign IFID_flush_o   = ctrl.ifid_flush;
  assign IDEX_flush_o   = ctrl.idex_flush;
  assign MEMWB_bubble_o = ctrl.memwb_bubble;

  // Watchdog: restart on entry to MEM_WAIT, count MEM_WAIT cycles without ack.
  assign timer_clear  = (state_q == RUN) && mem_stall;
  assign timer_enable = (state_q == MEM_WAIT) && !MEM_ack_i;

  pipe_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .hit_o    (timer_hit)
  );

  assign timeout_d     = timeout_q | timer_hit;
  assign mem_timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running, wraps naturally at 2^32.
  assign stall_cnt_d = stall_cnt_q + 32'(!ctrl.pc_write);
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed testbench for pipe_hazard_ctrl built with WAIT_MAX=4.
// Control outputs are compared as a 7-bit vector
//   {PC, IFID, IDEX, EXMEM write, IFID flush, IDEX flush, MEMWB bubble}.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [6:0] E_RUN = 7'b1111_000;
  localparam logic [6:0] E_RST = 7'b0000_000;
  localparam logic [6:0] E_MEM = 7'b0000_001;
  localparam logic [6:0] E_BR  = 7'b1111_110;
  localparam logic [6:0] E_LU  = 7'b0011_010;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] IFID_rs_i = '0, IFID_rt_i = '0, IDEX_rt_i = '0;
  logic       IDEX_MemRead_i = 1'b0, EX_branch_taken_i = 1'b0;
  logic       MEM_req_i = 1'b0, MEM_ack_i = 1'b0;
  logic       PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o;
  logic       IFID_flush_o, IDEX_flush_o, MEMWB_bubble_o, mem_timeout_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int          tests = 0;
  int          fails = 0;
  int unsigned exp_stall = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(
    .WAIT_MAX (4)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IFID_rs_i         (IFID_rs_i),
    .IFID_rt_i         (IFID_rt_i),
    .IDEX_MemRead_i    (IDEX_MemRead_i),
    .IDEX_rt_i         (IDEX_rt_i),
    .EX_branch_taken_i (EX_branch_taken_i),
    .MEM_req_i         (MEM_req_i),
    .MEM_ack_i         (MEM_ack_i),
    .PC_write_o        (PC_write_o),
    .IFID_write_o      (IFID_write_o),
    .IDEX_write_o      (IDEX_write_o),
    .EXMEM_write_o     (EXMEM_write_o),
    .IFID_flush_o      (IFID_flush_o),
    .IDEX_flush_o      (IDEX_flush_o),
    .MEMWB_bubble_o    (MEMWB_bubble_o),
    .mem_timeout_o     (mem_timeout_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  wire [6:0] ctrl_obs = {PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o,
                         IFID_flush_o, IDEX_flush_o, MEMWB_bubble_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic memread,
                       input logic [4:0] ex_rt, input logic br, input logic req,
                       input logic ack);
    IFID_rs_i         = rs;
    IFID_rt_i         = rt;
    IDEX_MemRead_i    = memread;
    IDEX_rt_i         = ex_rt;
    EX_branch_taken_i = br;
    MEM_req_i         = req;
    MEM_ack_i         = ack;
  endtask

  // Check the combinational outputs for the driven inputs, then let one
  // clock edge pass and return on the next falling edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, ctrl_obs}, {25'd0, exp});
    $display("[TB] %s: ctrl=%b expected=%b timeout=%0b", tag, ctrl_obs, exp, mem_timeout_o);
    if (!exp[6]) exp_stall++;
    @(negedge clk_i);
  endtask

  initial begin
    // Reset held with hazard-provoking inputs: outputs must still be zero.
    drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    #2;
    chk("reset_ctrl", {25'd0, ctrl_obs}, {25'd0, E_RST});
    chk("reset_timeout", {31'd0, mem_timeout_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    chk("reset_state", {31'd0, dut.state_q}, {31'd0, RUN});

    cyc("idle", E_RUN);

    // Load-use on rs, then the NOP'd ID/EX (MemRead=0) releases.
    drive(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cyc("lduse_rs", E_LU);
    drive(5'd8, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lduse_release", E_RUN);
    // Load-use on rt.
    drive(5'd3, 5'd17, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0);
    cyc("lduse_rt", E_LU);
    // r0 destination never interlocks.
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lduse_r0", E_RUN);
    // Non-matching registers.
    drive(5'd8, 5'd10, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("lduse_nomatch", E_RUN);
    // Match without MemRead.
    drive(5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("no_memread", E_RUN);
    // Branch with simultaneous load-use: branch flush only.
    drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc("branch_lduse", E_BR);
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    cyc("branch", E_BR);

    // Request acked in the same cycle: no stall, stays in RUN.
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
    cyc("req_ack_same", E_RUN);
    chk("req_ack_state", {31'd0, dut.state_q}, {31'd0, RUN});

    // Three wait cycles (one with a branch, still memory stall), then ack.
    drive(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
    cyc("mem_wait1", E_MEM);
    chk("mem_state_wait", {31'd0, dut.state_q}, {31'd0, MEM_WAIT});
    EX_branch_taken_i = 1'b1;
    cyc("mem_wait2_branch", E_MEM);
    cyc("mem_wait3", E_MEM);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("mem_ack", E_RUN);
    chk("mem_state_run", {31'd0, dut.state_q}, {31'd0, RUN});
    chk("mem_no_timeout", {31'd0, mem_timeout_o}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_mid", stall_cnt_o, exp_stall);
`endif

    // Watchdog: entry cycle clears, then MEM_WAIT cycles count 1..4.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("wd_cycle%0d", i), E_MEM);
      chk($sformatf("wd_timeout%0d", i), {31'd0, mem_timeout_o}, {31'd0, (i >= 4)});
    end
    chk("wd_saturated", {16'd0, dut.u_timer.cnt_q}, 32'd4);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("wd_ack", E_RUN);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("wd_after", E_RUN);
    chk("wd_sticky", {31'd0, mem_timeout_o}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_pre_rst", stall_cnt_o, exp_stall);
`endif

    // Reset pulsed mid-wait, away from any clock edge.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("rst_wait1", E_MEM);
    cyc("rst_wait2", E_MEM);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_async_ctrl", {25'd0, ctrl_obs}, {25'd0, E_RST});
    chk("rst_async_timeout", {31'd0, mem_timeout_o}, 32'd0);
    chk("rst_async_state", {31'd0, dut.state_q}, {31'd0, RUN});
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    $display("[TB] rst_pulse: ctrl=%b timeout=%0b", ctrl_obs, mem_timeout_o);
    @(negedge clk_i);
    @(negedge clk_i);
    exp_stall = 0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    cyc("post_rst_run", E_RUN);
    chk("post_rst_state", {31'd0, dut.state_q}, {31'd0, RUN});
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("post_rst_lduse", E_LU);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_final", stall_cnt_o, exp_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: WAIT_MAX, default 255, MEM-wait cycle count at which mem_timeout_o sets (1..65535).
REQ-002 clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 IFID_rs_i, IFID_rt_i  in  5 each  source registers of the instruction in ID.
REQ-005 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-006 IDEX_rt_i  in  5  destination register of that load.
REQ-007 EX_branch_taken_i  in  1  branch/jump resolved taken in EX.
REQ-008 MEM_req_i  in  1  instruction in MEM accesses data memory.
REQ-009 MEM_ack_i  in  1  data memory completes the access this cycle.
REQ-010 PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o  out  1 each  stage-register load enables.
REQ-011 IFID_flush_o, IDEX_flush_o  out  1 each  load zero/NOP into that stage register.
REQ-012 MEMWB_bubble_o  out  1  MEM/WB loads zero control (RegWrite=0, MemtoReg=0).
REQ-013 mem_timeout_o  out  1  sticky MEM-wait watchdog flag.

Function
REQ-014 Control outputs are combinational from current state and inputs; state, wait counter, and flags are registered.
REQ-015 FSM states: RUN, MEM_WAIT; RUN->MEM_WAIT when MEM_req_i=1 and MEM_ack_i=0; MEM_WAIT->RUN on the cycle MEM_ack_i=1; otherwise hold.
REQ-016 mem_stall = MEM_req_i & ~MEM_ack_i, in either state; entry and stall are asserted in the same cycle as the request.
REQ-017 mem_stall: PC/IFID/IDEX/EXMEM write=0, both flushes=0, MEMWB_bubble_o=1.
REQ-018 Branch flush (EX_branch_taken_i=1, no mem_stall): all writes=1, IFID_flush_o=1, IDEX_flush_o=1, bubble=0.
REQ-019 Load-use (IDEX_MemRead_i=1, IDEX_rt_i!=0, IDEX_rt_i equals IFID_rs_i or IFID_rt_i, no branch, no mem_stall): PC_write_o=0, IFID_write_o=0, IDEX_flush_o=1, IDEX/EXMEM write=1, bubble=0.
REQ-020 No hazard: all writes=1, flushes=0, bubble=0.
REQ-021 Priority: mem_stall > branch flush > load-use; a branch and load-use in the same cycle produce branch flush only.
REQ-022 Load-use stalls exactly one cycle, because the flushed ID/EX carries MemRead=0.
REQ-023 wait_cnt clears on entering MEM_WAIT, increments each MEM_WAIT cycle without ack, and saturates at WAIT_MAX.
REQ-024 When wait_cnt reaches WAIT_MAX, mem_timeout_o sets and holds until reset; the FSM keeps waiting.
REQ-025 A request with ack in the same cycle causes no stall and no state change.

Reset
REQ-026 While rst_i=0: state=RUN, wait_cnt=0, mem_timeout_o=0, all write enables=0, flushes=0, MEMWB_bubble_o=0.
REQ-027 Reset mid-MEM_WAIT abandons the wait immediately; the first cycle after release behaves as RUN.

Configuration
REQ-028 With HAZARD_PERF_CNT_EN defined: output stall_cnt_o[31:0] counts cycles with PC_write_o=0, wraps at 2^32, and resets to 0.
REQ-029 Without HAZARD_PERF_CNT_EN: the stall_cnt_o port and counter logic are absent; other behaviour is identical.

Structure
REQ-030 Shared package pipe_ctrl_pkg holds the FSM state encoding (RUN=0, MEM_WAIT=1), REG_ZERO=5'd0, and the register-index width 5.
REQ-031 The watchdog counter is a sub-module pipe_wait_timer, with clear/enable/saturate and WAIT_MAX passed down.

Verification
REQ-032 lw $t0 in EX (IDEX_rt_i=8, MemRead=1), IFID_rs_i=8 -> one cycle PC_write_o=0, IFID_write_o=0, IDEX_flush_o=1; next cycle all writes=1.
REQ-033 IDEX_rt_i=0, MemRead=1, IFID_rs_i=0 -> no stall.
REQ-034 EX_branch_taken_i=1 with a load-use match -> IFID_flush_o=1, IDEX_flush_o=1, PC_write_o=1.
REQ-035 MEM_req_i=1, ack after 3 cycles -> 3 cycles with all writes=0 and MEMWB_bubble_o=1; release on the ack cycle; state back to RUN.
REQ-036 WAIT_MAX=4, ack withheld 10 cycles -> mem_timeout_o rises after the 4th wait cycle, stays 1 after ack, and clears only on rst_i=0.
REQ-037 rst_i pulsed low mid-wait -> all outputs at reset values asynchronously; RUN after release; stall_cnt_o=0 when HAZARD_PERF_CNT_EN is defined.
